// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles every signal of the MEM stage except clock and reset.
//   ex_*        : EX/MEM latch contents (driven upstream, held while mem_stall=1)
//   dhit/dmemload, dmemREN/WEN/addr/store : data-cache handshake
//   mem_stall   : freeze request towards upstream stages
//   wb_*        : registered MEM/WB latch contents
//   err_*       : sticky error flags
// Modports: slave = the MEM stage itself, master = its environment.
interface mem_stage_if;
    logic        ex_valid;
    logic        ex_dREN;
    logic        ex_dWEN;
    logic [31:0] ex_daddr;
    logic [31:0] ex_dstore;
    logic        ex_regWr;
    logic [4:0]  ex_wsel;
    logic [1:0]  ex_memToReg;
    logic        ex_halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        mem_stall;
    logic        wb_valid;
    logic        wb_regWr;
    logic        wb_halt;
    logic [4:0]  wb_wsel;
    logic [1:0]  wb_memToReg;
    logic [31:0] wb_dmemload;
    logic        err_timeout;
    logic        err_align;

    modport slave (
        input  ex_valid, ex_dREN, ex_dWEN, ex_daddr, ex_dstore, ex_regWr,
               ex_wsel, ex_memToReg, ex_halt, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               wb_valid, wb_regWr, wb_halt, wb_wsel, wb_memToReg, wb_dmemload,
               err_timeout, err_align
    );

    modport master (
        output ex_valid, ex_dREN, ex_dWEN, ex_daddr, ex_dstore, ex_regWr,
               ex_wsel, ex_memToReg, ex_halt, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               wb_valid, wb_regWr, wb_halt, wb_wsel, wb_memToReg, wb_dmemload,
               err_timeout, err_align
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage. Issues data-cache requests combinationally
// from the EX/MEM latch, stalls upstream until the cache hits, registers the
// result into MEM/WB, and halts on a halt instruction or an access timeout.
// Ports:
//   CLK   : clock, all state on rising edge
//   nRST  : asynchronous active-low reset
//   bus   : mem_stage_if.slave (EX/MEM inputs, cache handshake, MEM/WB outputs)
// Parameter TIMEOUT (1..255): WAIT cycles without a hit before giving up.
module mem_stage #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic        CLK,
    input logic        nRST,
    mem_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_regWr_q, wb_regWr_d;
    logic        wb_halt_q, wb_halt_d;
    logic [4:0]  wb_wsel_q, wb_wsel_d;
    logic [1:0]  wb_memToReg_q, wb_memToReg_d;
    logic [31:0] wb_dmemload_q, wb_dmemload_d;
    logic        err_timeout_q, err_timeout_d;
    logic        err_align_q, err_align_d;

    logic mem_op, misaligned, access, stall;

    // Request path. nRST is folded into access so requests drop the instant
    // reset asserts, even before the state register is seen as IDLE.
    always_comb begin
        mem_op     = bus.ex_valid & (bus.ex_dREN | bus.ex_dWEN);
        misaligned = mem_op & (bus.ex_daddr[1:0] != 2'b00);
        access     = mem_op & ~misaligned & (state_q != HALTED) & nRST;
        stall      = (access & ~bus.dhit) | (state_q == HALTED);
    end

    assign bus.dmemWEN     = access & bus.ex_dWEN;
    assign bus.dmemREN     = access & bus.ex_dREN & ~bus.ex_dWEN;  // store wins
    assign bus.dmemaddr    = access ? bus.ex_daddr  : 32'h0;
    assign bus.dmemstore   = access ? bus.ex_dstore : 32'h0;
    assign bus.mem_stall   = stall;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_regWr    = wb_regWr_q;
    assign bus.wb_halt     = wb_halt_q;
    assign bus.wb_wsel     = wb_wsel_q;
    assign bus.wb_memToReg = wb_memToReg_q;
    assign bus.wb_dmemload = wb_dmemload_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_align   = err_align_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wb_valid_d    = wb_valid_q;
        wb_regWr_d    = wb_regWr_q;
        wb_halt_d     = wb_halt_q;
        wb_wsel_d     = wb_wsel_q;
        wb_memToReg_d = wb_memToReg_q;
        wb_dmemload_d = wb_dmemload_q;
        err_timeout_d = err_timeout_q;
        err_align_d   = err_align_q | misaligned;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (access & ~bus.dhit) state_d = WAIT;
            end
            WAIT: begin
                // Losing access here would mean upstream dropped a stalled
                // request; treat it like completion rather than hang.
                if (bus.dhit | ~access) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_CNT) begin
                        err_timeout_d = 1'b1;
                        state_d       = HALTED;
                    end
                end
            end
            HALTED: ;
            default: state_d = IDLE;
        endcase

        if (!stall) begin
            wb_valid_d    = bus.ex_valid & ~misaligned;
            wb_regWr_d    = bus.ex_regWr;
            wb_wsel_d     = bus.ex_wsel;
            wb_memToReg_d = bus.ex_memToReg;
            wb_dmemload_d = (bus.dmemREN & bus.dhit) ? bus.dmemload : 32'h0;
            if (bus.ex_valid & bus.ex_halt) begin
                wb_halt_d = 1'b1;
                state_d   = HALTED;
            end
        end else begin
            wb_valid_d = 1'b0;  // bubble; other fields hold
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            wb_valid_q    <= 1'b0;
            wb_regWr_q    <= 1'b0;
            wb_halt_q     <= 1'b0;
            wb_wsel_q     <= 5'd0;
            wb_memToReg_q <= 2'd0;
            wb_dmemload_q <= 32'h0;
            err_timeout_q <= 1'b0;
            err_align_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wb_valid_q    <= wb_valid_d;
            wb_regWr_q    <= wb_regWr_d;
            wb_halt_q     <= wb_halt_d;
            wb_wsel_q     <= wb_wsel_d;
            wb_memToReg_q <= wb_memToReg_d;
            wb_dmemload_q <= wb_dmemload_d;
            err_timeout_q <= err_timeout_d;
            err_align_q   <= err_align_d;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage with a transaction-level model.
// The driver issues one instruction at a time (with a chosen cache latency),
// pushes its expected MEM/WB retirement into a scoreboard, and a negedge
// monitor pops and compares whenever wb_valid is seen.
module tb_mem_stage;
    localparam int TO = 4;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT(TO)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic        regWr;
        logic [4:0]  wsel;
        logic [1:0]  m2r;
        logic [31:0] load;
        logic        halt;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mem [int];
    bit          halted_m, halt_m, erra_m, errt_m;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every retirement must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (nRST === 1'b1 && bus.wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wb: wb_valid=1 with empty scoreboard (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_regWr",    32'(bus.wb_regWr),    32'(mon_e.regWr));
                chk("wb_wsel",     32'(bus.wb_wsel),     32'(mon_e.wsel));
                chk("wb_memToReg", 32'(bus.wb_memToReg), 32'(mon_e.m2r));
                chk("wb_dmemload", bus.wb_dmemload,      mon_e.load);
                chk("wb_halt",     32'(bus.wb_halt),     32'(mon_e.halt));
            end
        end
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return {a[15:0], 16'hC0DE};
    endfunction

    // Issue one instruction starting at a negedge; d = cycle index (0-based)
    // in which the cache hits. Returns at the negedge after it leaves MEM.
    task automatic op(input bit v, input bit ren, input bit wen,
                      input logic [31:0] addr, input logic [31:0] sdat,
                      input int d, input bit halt);
        bit          memop, mis, acc, stall_exp, is_load;
        logic [31:0] ld;
        exp_t        e;
        int          k;
        memop   = v && (ren || wen);
        mis     = memop && (addr[1:0] != 2'b00);
        acc     = memop && !mis && !halted_m;
        is_load = acc && ren && !wen;
        ld      = mem_rd(addr);
        bus.ex_valid    = v;
        bus.ex_dREN     = ren;
        bus.ex_dWEN     = wen;
        bus.ex_daddr    = addr;
        bus.ex_dstore   = sdat;
        bus.ex_regWr    = 1'($urandom);
        bus.ex_wsel     = 5'($urandom);
        bus.ex_memToReg = 2'($urandom);
        bus.ex_halt     = halt;
        k = 0;
        forever begin
            if (acc) begin
                bus.dhit     = (k == d);
                bus.dmemload = (k == d) ? ld : $urandom;
            end else begin
                bus.dhit     = 1'($urandom);  // stray hits must be ignored
                bus.dmemload = $urandom;
            end
            stall_exp = halted_m || (acc && k != d);
            if (!stall_exp && v && !mis) begin
                e.regWr = bus.ex_regWr;
                e.wsel  = bus.ex_wsel;
                e.m2r   = bus.ex_memToReg;
                e.load  = is_load ? ld : 32'h0;
                e.halt  = halt_m || halt;
                sb.push_back(e);
            end
            #1;
            chk("dmemREN",   32'(bus.dmemREN),   32'(is_load));
            chk("dmemWEN",   32'(bus.dmemWEN),   32'(acc && wen));
            chk("mem_stall", 32'(bus.mem_stall), 32'(stall_exp));
            if (acc) begin
                chk("dmemaddr",  bus.dmemaddr,  addr);
                chk("dmemstore", bus.dmemstore, sdat);
            end
            @(negedge CLK);
            if (mis) erra_m = 1'b1;
            if (halted_m) break;
            if (!stall_exp) begin
                if (v && halt) begin halted_m = 1'b1; halt_m = 1'b1; end
                if (acc && wen) mem[int'(addr)] = sdat;
                break;
            end
            // cycle k>=1 was a WAIT cycle without a hit
            if (k >= 1 && k == TO) begin
                errt_m   = 1'b1;
                halted_m = 1'b1;
                break;
            end
            k++;
        end
        chk("err_align",   32'(bus.err_align),   32'(erra_m));
        chk("err_timeout", 32'(bus.err_timeout), 32'(errt_m));
        chk("wb_halt_now", 32'(bus.wb_halt),     32'(halt_m));
    endtask

    task automatic reset_checks();
        #1;
        chk("rst_dmemREN",     32'(bus.dmemREN),     0);
        chk("rst_dmemWEN",     32'(bus.dmemWEN),     0);
        chk("rst_mem_stall",   32'(bus.mem_stall),   0);
        chk("rst_wb_valid",    32'(bus.wb_valid),    0);
        chk("rst_wb_halt",     32'(bus.wb_halt),     0);
        chk("rst_wb_regWr",    32'(bus.wb_regWr),    0);
        chk("rst_wb_dmemload", bus.wb_dmemload,      0);
        chk("rst_err_timeout", 32'(bus.err_timeout), 0);
        chk("rst_err_align",   32'(bus.err_align),   0);
        sb.delete();
        halted_m = 0; halt_m = 0; erra_m = 0; errt_m = 0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Reset with a live aligned load presented: requests must still be 0.
    task automatic do_reset();
        bus.ex_valid = 1'b1; bus.ex_dREN = 1'b1; bus.ex_dWEN = 1'b0;
        bus.ex_daddr = 32'h80; bus.dhit = 1'b0;
        nRST = 1'b0;
        reset_checks();
    endtask

    task automatic reset_mid_wait();
        bus.ex_valid = 1'b1; bus.ex_dREN = 1'b1; bus.ex_dWEN = 1'b0;
        bus.ex_daddr = 32'h44; bus.ex_halt = 1'b0; bus.dhit = 1'b0;
        #1;
        chk("mw_req_before", 32'(bus.dmemREN), 1);
        @(negedge CLK);
        #1;
        chk("mw_stall_wait", 32'(bus.mem_stall), 1);
        nRST = 1'b0;
        reset_checks();
    endtask

    initial begin
        bus.ex_valid = 0; bus.ex_dREN = 0; bus.ex_dWEN = 0; bus.ex_daddr = 0;
        bus.ex_dstore = 0; bus.ex_regWr = 0; bus.ex_wsel = 0; bus.ex_memToReg = 0;
        bus.ex_halt = 0; bus.dhit = 0; bus.dmemload = 0;
        halted_m = 0; halt_m = 0; erra_m = 0; errt_m = 0;
        mem[32'h100] = 32'hDEADBEEF;
        do_reset();

        // First post-reset instruction: zero-wait store
        op(1, 0, 1, 32'h40, 32'h12345678, 0, 0);
        // Load with hit in the 4th cycle
        op(1, 1, 0, 32'h100, 32'h0, 3, 0);
        // Both enables set: behaves as store
        op(1, 1, 1, 32'h48, 32'hCAFEF00D, 1, 0);
        op(1, 1, 0, 32'h48, 32'h0, 0, 0);
        // Misaligned load
        op(1, 1, 0, 32'h102, 32'h0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            a    = 32'($urandom_range(0, 15)) << 2;
            case (kind)
                0:       op(0, 1'($urandom), 1'($urandom), a, $urandom, 0, 0);
                1:       op(1, 0, 0, a, $urandom, 0, 0);
                2, 3, 4: op(1, 1, 0, a, $urandom, $urandom_range(0, TO), 0);
                5, 6:    op(1, 0, 1, a, $urandom, $urandom_range(0, TO), 0);
                7:       op(1, 1, 1, a, $urandom, $urandom_range(0, TO), 0);
                default: op(1, 1'($urandom), 1'b1, a | 32'($urandom_range(1, 3)), $urandom, 0, 0);
            endcase
        end

        // Halt, then a load that must not issue
        op(1, 0, 0, 32'h0, 32'h0, 0, 1);
        op(1, 1, 0, 32'h100, 32'h0, 0, 0);
        op(1, 0, 1, 32'h104, 32'h1, 0, 0);
        do_reset();

        reset_mid_wait();
        op(1, 1, 0, 32'h100, 32'h0, 1, 0);

        // Timeout: cache never answers within the budget
        op(1, 1, 0, 32'h3C, 32'h0, TO + 3, 0);
        op(1, 1, 0, 32'h3C, 32'h0, 0, 0);
        op(1, 0, 1, 32'h38, 32'h0, 0, 0);
        chk("sb_drain", 32'(sb.size()), 0);
        do_reset();
        op(1, 1, 0, 32'h100, 32'h0, 2, 0);
        op(0, 0, 0, 32'h0, 32'h0, 0, 0);
        chk("sb_drain_end", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 64, range 1..255: maximum WAIT cycles before a data access is declared failed.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: CLK and nRST.
REQ-003 Ports SHALL be:
- CLK  in  1  clock, all state on rising edge.
- nRST  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX/MEM latch holds a real instruction.
- ex_dREN  in  1  instruction is a load.
- ex_dWEN  in  1  instruction is a store.
- ex_daddr  in  32  effective address (ALU result).
- ex_dstore  in  32  store data.
- ex_regWr  in  1  register write enable.
- ex_wsel  in  5  destination register.
- ex_memToReg  in  2  writeback mux select.
- ex_halt  in  1  halt instruction.
- dhit  in  1  data cache completed the current access.
- dmemload  in  32  load data, valid when dhit.
- dmemREN  out  1  data read request.
- dmemWEN  out  1  data write request.
- dmemaddr  out  32  data address.
- dmemstore  out  32  data to store.
- mem_stall  out  1  freeze upstream stages this cycle.
- wb_valid, wb_regWr, wb_halt  out  1 each  registered towards MEM/WB.
- wb_wsel  out  5; wb_memToReg  out  2; wb_dmemload  out  32  registered towards MEM/WB.
- err_timeout, err_align  out  1 each  sticky error flags.

Function
REQ-004 FSM states: IDLE, WAIT, HALTED; reset state IDLE.
REQ-005 access = ex_valid & (ex_dREN | ex_dWEN) & (ex_daddr[1:0]==0) & state!=HALTED & nRST.
REQ-006 When access: dmemWEN = ex_dWEN; dmemREN = ex_dREN & !ex_dWEN (write wins if both set); dmemaddr = ex_daddr; dmemstore = ex_dstore; otherwise all four SHALL be 0.
REQ-007 Requests SHALL be combinational from ex_* in IDLE and WAIT, held stable by upstream while mem_stall=1.
REQ-008 mem_stall = (access & !dhit) | (state==HALTED).
REQ-009 IDLE -> WAIT when access & !dhit; WAIT -> IDLE when dhit; a zero-wait access (dhit same cycle) stays in IDLE.
REQ-010 8-bit wait counter: cleared in IDLE, increments each WAIT cycle without dhit; when it reaches TIMEOUT, err_timeout <= 1, state <= HALTED, requests drop.
REQ-011 Misaligned access (ex_valid & (dREN|dWEN) & ex_daddr[1:0]!=0): no request, no stall, err_align <= 1, instruction retired as bubble (wb_valid=0).
REQ-012 Output register update when !mem_stall: wb_valid <= ex_valid & !misaligned; wb_regWr, wb_wsel, wb_memToReg <= ex_*; wb_dmemload <= dmemload if dmemREN&dhit else 0.
REQ-013 When mem_stall: wb_valid <= 0 (bubble); other wb_* fields hold.
REQ-014 Halt: ex_valid & ex_halt & !mem_stall -> wb_halt <= 1, state <= HALTED.
REQ-015 HALTED is absorbing until reset: no requests, wb_valid=0, mem_stall=1, wb_halt held 1.
REQ-016 err_timeout, err_align SHALL be sticky until nRST.
REQ-017 dhit while no access SHALL be ignored.

Reset
REQ-018 nRST low SHALL immediately force state IDLE, counter 0, all wb_* 0, err_* 0, and dmemREN/dmemWEN 0 regardless of ex_* inputs, including mid-WAIT.
REQ-019 First post-reset edge with ex_valid=1 SHALL be processed normally.

Verification
REQ-020 Load addr 0x100, dhit after 3 cycles with 0xDEADBEEF -> dmemREN=1 for 4 cycles, mem_stall=1 for 3, then wb_valid=1, wb_dmemload=0xDEADBEEF; 3 preceding wb_valid=0 bubbles.
REQ-021 Store addr 0x40, data 0x12345678, dhit same cycle -> dmemWEN=1 one cycle, no stall, wb_valid=1, wb_dmemload=0.
REQ-022 dREN=dWEN=1 -> dmemWEN=1, dmemREN=0.
REQ-023 Load addr 0x102 -> no request, err_align=1, wb_valid=0, mem_stall=0.
REQ-024 TIMEOUT=4, load never hit -> err_timeout=1 after 4 WAIT cycles, state HALTED, dmemREN=0, mem_stall=1 persistent.
REQ-025 Halt instruction -> wb_halt=1 next edge, subsequent loads issue no request; nRST pulse mid-WAIT -> requests drop immediately, all outputs 0.
